// File: rtl/arb_defs.sv
// Shared arbiter definitions: FSM state encoding and default sizing.
//   ST_IDLE / ST_GRANT  - grant controller states
//   NUMUNITS_DEF, IDXW_DEF - default requester count and index width
package arb_defs;

  localparam int unsigned NUMUNITS_DEF = 9;
  localparam int unsigned IDXW_DEF     = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping mod N.
//   request  in  N   request levels
//   ptr      in  IW  starting index of the scan (must be < N)
//   found    out 1   any request set
//   winner   out IW  index of the selected requester (0 when none)
module rr_pick
  import arb_defs::*;
#(
  parameter int unsigned N  = NUMUNITS_DEF,
  parameter int unsigned IW = IDXW_DEF
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [2*N-1:0] rot;
  int unsigned    pos;

  // Doubling the vector and shifting by ptr puts the scan origin at bit 0.
  always_comb begin
    rot    = {request, request} >> ptr;
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        pos    = i + 32'(ptr);
        winner = (pos >= N) ? IW'(pos - N) : IW'(pos);
      end
    end
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Round-robin burst grant controller with no-progress watchdog.
//   clock        in  1              rising-edge clock
//   reset        in  1              synchronous, active-low
//   request      in  NUMUNITS       per-unit request level
//   burst_len    in  NUMUNITS*LENW  unit i beats-1 at [i*LENW +: LENW]
//   beat         in  1              granted unit moved one beat
//   grant        out NUMUNITS       registered one-hot grant
//   grant_valid  out 1              |grant
//   grant_id     out IDXW           index of granted unit, holds when idle
//   timeout_err  out 1              pulse in first idle cycle after watchdog release
module arb_grant_ctrl
  import arb_defs::*;
#(
  parameter int unsigned NUMUNITS = NUMUNITS_DEF,
  parameter int unsigned IDXW     = IDXW_DEF,
  parameter int unsigned LENW     = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUMUNITS-1:0]      request,
  input  logic [NUMUNITS*LENW-1:0] burst_len,
  input  logic                     beat,
  output logic [NUMUNITS-1:0]      grant,
  output logic                     grant_valid,
  output logic [IDXW-1:0]          grant_id,
  output logic                     timeout_err
);

  localparam int unsigned CNTW = 8;

  state_t              state, state_nxt;
  logic [NUMUNITS-1:0] grant_nxt;
  logic                grant_valid_nxt;
  logic [IDXW-1:0]     grant_id_nxt;
  logic                timeout_err_nxt;
  logic [IDXW-1:0]     ptr, ptr_nxt;
  logic [LENW-1:0]     beats_left, beats_left_nxt;
  logic [CNTW-1:0]     idle_cnt, idle_cnt_nxt;

  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic [LENW-1:0]     pick_len;
  logic                release_c;

  rr_pick #(
    .N  (NUMUNITS),
    .IW (IDXW)
  ) u_pick (
    .request (request),
    .ptr     (ptr),
    .found   (pick_found),
    .winner  (pick_idx)
  );

  assign pick_len = LENW'(burst_len >> (32'(pick_idx) * LENW));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    timeout_err_nxt = 1'b0;
    ptr_nxt         = ptr;
    beats_left_nxt  = beats_left;
    idle_cnt_nxt    = idle_cnt;
    release_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt      = ST_GRANT;
          grant_nxt      = NUMUNITS'(1) << pick_idx;
          grant_id_nxt   = pick_idx;
          beats_left_nxt = pick_len;
          idle_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        // Beat outranks both abort and watchdog so a final beat always ends cleanly.
        if (beat && beats_left == '0) begin
          release_c = 1'b1;
        end else if (beat) begin
          beats_left_nxt = beats_left - LENW'(1);
          idle_cnt_nxt   = '0;
        end else if ((request & grant) == '0) begin
          release_c = 1'b1;
        end else if (idle_cnt == CNTW'(TIMEOUT - 1)) begin
          release_c       = 1'b1;
          timeout_err_nxt = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + CNTW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (release_c) begin
      state_nxt = ST_IDLE;
      grant_nxt = '0;
      ptr_nxt   = (grant_id == IDXW'(NUMUNITS - 1)) ? '0 : grant_id + IDXW'(1);
    end

    grant_valid_nxt = |grant_nxt;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      beats_left  <= '0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      timeout_err <= timeout_err_nxt;
      ptr         <= ptr_nxt;
      beats_left  <= beats_left_nxt;
      idle_cnt    <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Bench for arb_grant_ctrl: directed scenarios then random traffic, all
// cross-checked every cycle against a behavioural arbiter model.
module tb_arb_grant_ctrl;

  localparam int N  = 9;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int TO = 15;
  localparam int BW = N * LW;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  request;
  logic [BW-1:0] burst_len;
  logic          beat;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_busy = 0;
  bit m_terr = 0;
  int m_gid = 0, m_beats = 0, m_idle = 0, m_ptr = 0;

  always #5 clock = ~clock;

  arb_grant_ctrl #(
    .NUMUNITS (N),
    .IDXW     (IW),
    .LENW     (LW),
    .TIMEOUT  (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .burst_len   (burst_len),
    .beat        (beat),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int field(input int u);
    logic [BW-1:0] t;
    t = burst_len >> (u * LW);
    return int'(t[LW-1:0]);
  endfunction

  task automatic set_len(input int u, input int v);
    burst_len[u*LW +: LW] = LW'(v);
  endtask

  task automatic model_release();
    m_busy = 0;
    m_ptr  = (m_gid + 1) % N;
  endtask

  // Advance the model by one clock using inputs as sampled at the edge.
  task automatic model_step();
    m_terr = 0;
    if (!reset) begin
      m_busy = 0; m_gid = 0; m_beats = 0; m_idle = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        int u;
        u = (m_ptr + i) % N;
        if (!m_busy && request[u]) begin
          m_busy  = 1;
          m_gid   = u;
          m_beats = field(u);
          m_idle  = 0;
        end
      end
    end else begin
      if (beat && m_beats == 0) begin
        model_release();
      end else if (beat) begin
        m_beats--;
        m_idle = 0;
      end else if (!request[m_gid]) begin
        model_release();
      end else if (m_idle == TO - 1) begin
        model_release();
        m_terr = 1;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("grant", 32'(grant), m_busy ? (32'd1 << m_gid) : 32'd0);
    chk("grant_valid", 32'(grant_valid), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("ptr", 32'(dut.ptr), 32'(m_ptr));
  endtask

  initial begin
    int thr;
    reset = 1'b0; request = '0; burst_len = '0; beat = 1'b0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h0);

    // Single 3-beat burst on unit 4
    reset = 1'b1; request = 9'h010; set_len(4, 2); beat = 1'b1;
    tick();
    chk("u4_grant", 32'(grant), 32'h010);
    chk("u4_id", 32'(grant_id), 32'd4);
    tick(); tick();
    chk("u4_still", 32'(grant), 32'h010);
    tick();
    request = '0;
    chk("u4_release", 32'(grant), 32'h0);
    chk("u4_ptr", 32'(dut.ptr), 32'd5);

    // Rotation 7, 8, 0, 7 with idle gaps
    burst_len = '0; request = 9'h181; beat = 1'b1;
    tick(); chk("rr_g1", 32'(grant_id), 32'd7); chk("rr_v1", 32'(grant_valid), 32'd1);
    tick(); chk("rr_gap1", 32'(grant), 32'h0);
    tick(); chk("rr_g2", 32'(grant_id), 32'd8);
    tick(); chk("rr_gap2", 32'(grant), 32'h0);
    tick(); chk("rr_g3", 32'(grant_id), 32'd0);
    tick(); chk("rr_gap3", 32'(grant), 32'h0);
    tick(); chk("rr_g4", 32'(grant), 32'h080);
    tick(); chk("rr_gap4", 32'(grant), 32'h0);

    // Watchdog on unit 2, then unit 3 wins
    request = 9'h00C; beat = 1'b0;
    tick(); chk("wd_grant", 32'(grant), 32'h004);
    for (int k = 0; k < TO - 1; k++) tick();
    chk("wd_hold", 32'(grant), 32'h004);
    chk("wd_noerr", 32'(timeout_err), 32'd0);
    tick();
    chk("wd_release", 32'(grant), 32'h0);
    chk("wd_err", 32'(timeout_err), 32'd1);
    tick();
    chk("wd_next", 32'(grant), 32'h008);
    chk("wd_pulse_end", 32'(timeout_err), 32'd0);
    request = '0;
    tick();
    chk("abort3", 32'(grant), 32'h0);

    // Abort of unit 1 after two beats
    set_len(1, 5); request = 9'h002;
    tick(); chk("ab_grant", 32'(grant), 32'h002);
    beat = 1'b1; tick(); tick();
    request = '0; beat = 1'b0;
    tick();
    chk("ab_release", 32'(grant), 32'h0);
    chk("ab_noerr", 32'(timeout_err), 32'd0);
    chk("ab_ptr", 32'(dut.ptr), 32'd2);

    // Final beat coincides with watchdog threshold
    set_len(5, 0); request = 9'h020; beat = 1'b0;
    tick(); chk("fb_grant", 32'(grant), 32'h020);
    for (int k = 0; k < TO - 1; k++) tick();
    beat = 1'b1;
    tick();
    chk("fb_release", 32'(grant), 32'h0);
    chk("fb_noerr", 32'(timeout_err), 32'd0);
    request = '0; beat = 1'b0;
    tick();

    // Reset in the middle of a burst
    request = '1; beat = 1'b1;
    for (int u = 0; u < N; u++) set_len(u, 3);
    tick(); chk("mr_grant", 32'(grant), 32'h040);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_grant0", 32'(grant), 32'h0);
    chk("mr_valid0", 32'(grant_valid), 32'd0);
    chk("mr_id0", 32'(grant_id), 32'd0);
    chk("mr_err0", 32'(timeout_err), 32'd0);
    reset = 1'b1; beat = 1'b0;
    tick();
    chk("mr_first", 32'(grant), 32'h001);

    // Random traffic against the model
    thr = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) thr = int'($urandom_range(0, 8));
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) request = N'($urandom()) & N'($urandom());
      if ($urandom_range(0, 15) == 0) burst_len = BW'({$urandom(), $urandom()});
      beat = (int'($urandom_range(0, 7)) < thr);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_grant_ctrl.md
# arb_grant_ctrl

Round-robin grant controller that shares one downstream resource among NUMUNITS requesters and holds each grant for a multi-beat burst. It sits between the requesting units and the shared datapath port. It selects a winner, holds the grant until the burst's beats complete, and enforces a no-progress watchdog. The grant is registered and one-hot, so the downstream mux is driven directly from `grant_id`.

## Interface
- NUMUNITS, 9, number of requesters (2..16)
- IDXW, 4, width of requester index; 2**IDXW >= NUMUNITS
- LENW, 4, width of per-unit burst length field
- TIMEOUT, 15, consecutive no-beat cycles in a grant before forced release (1..255)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clock clock
- request  in  NUMUNITS  per-unit request level; held until burst done
- burst_len  in  NUMUNITS*LENW  unit i field at [i*LENW +: LENW]; beats = field+1
- beat  in  1  granted unit transferred one beat this cycle
- grant  out  NUMUNITS  registered one-hot grant; 0 when none
- grant_valid  out  1  |grant
- grant_id  out  IDXW  index of granted unit; holds last value when idle
- timeout_err  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, GRANT.
- IDLE: `beat` ignored. If any request, pick the first set bit scanning ptr, ptr+1, …, wrapping mod NUMUNITS. Load grant, grant_id, beats_left = burst_len[winner], idle_cnt = 0, and enter GRANT.
- GRANT, evaluated each cycle in priority order:
  1. beat && beats_left==0 -> release (normal end).
  2. beat -> beats_left-1, idle_cnt = 0.
  3. request[grant_id]==0 -> release (abort), no error.
  4. idle_cnt==TIMEOUT-1 -> release, timeout_err=1 next cycle.
  5. Otherwise idle_cnt+1.
- Release: grant=0, state=IDLE, ptr = grant_id+1, wrapping NUMUNITS-1 -> 0.
- Ptr does not advance while idle with no requests.
- burst_len is sampled only at grant. Later changes are ignored until the next grant.
- Simultaneous final beat and request drop: the beat counts and the release is normal.
- Simultaneous final beat and timeout: the beat wins and no error pulses.
- Arithmetic: beats_left is LENW bits and never decrements below 0. idle_cnt is 8 bits.
- Reset, any state, including mid-burst: state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout_err=0, ptr=0, beats_left=0, idle_cnt=0.

## Timing
- Request high in IDLE at edge t -> grant high after edge t+1.
- Final beat sampled at edge t -> grant low after t+1. Earliest next grant is after t+2, so there is always at least one idle cycle between grants.
- Abort and timeout have the same 1-cycle release latency.
- timeout_err is high during exactly the first idle cycle after a watchdog release.
- grant, grant_valid, grant_id and timeout_err are all flop outputs with no combinational path from inputs.

## Structure
- Shared package/include `arb_defs`:
  - state encodings ST_IDLE / ST_GRANT
  - default NUMUNITS / IDXW constants shared with the other arbiter blocks
- Sub-module `rr_pick`:
  - combinational; inputs request and ptr
  - outputs found and winner index
  - scans the doubled request vector from ptr
  - reusable by the other arbiter blocks

## Test plan
- Reset, then request=9'h010, burst_len[4]=2, beat every cycle. Expect:
  - grant=9'h010 and grant_id=4 one cycle after the request
  - 3 beats accepted, grant=0 one cycle after the 3rd
  - ptr=5
- request=9'h181 with ptr=5 and single-beat bursts. Expect grant order 7, 8, 0, then wrap to 7, with one idle cycle between each grant.
- Grant unit 2, then hold beat=0 with TIMEOUT=15. Expect:
  - release after 15 cycles in GRANT
  - timeout_err high for exactly 1 cycle
  - next grant goes to unit 3 if it is requesting
- Grant unit 1 with burst_len=5, drop request[1] after 2 beats. Expect grant=0 next cycle, no timeout_err, ptr=2.
- Final beat in the same cycle idle_cnt reaches TIMEOUT-1. Expect normal release with timeout_err=0.
- reset low mid-burst for 1 cycle while request=all ones. Expect:
  - all outputs 0 the next cycle
  - the first grant after reset deassertion goes to unit 0
